fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_perf_counter.sv | 31 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencing: issue a request, wait for its word, hold it for decode.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-memory request/response, redirect and decode handoff.
// master = fetch unit side, slave = memory / execute / decode side.
interface fetch_if #(
  parameter int XLEN = fetch_pkg::XLEN
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_perf_counter.sv
// Two free-running wrap-around event counters: delivered fetches and decode stalls.
module fetch_perf_counter (
  input  logic        pCLK,
  input  logic        pRST,
  input  logic        fetched_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);
  logic [1:0] inc;
  assign inc = {stall_inc, fetched_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: add one on the event, wrap naturally at 2^32.
    always_comb begin
      cnt_d = cnt_q + 32'(inc[gi]);
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge pCLK) begin
      if (pRST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
  end

  assign perf_fetched = g_cnt[0].cnt_q;
  assign perf_stall   = g_cnt[1].cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/kill handling.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::DEFAULT_RESET_PC)
) (
  input  logic        pCLK,
  input  logic        pRST,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic            req_valid_q, req_valid_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] redir_pc;
  logic            accept;

  // Next-state and registered-output computation; redirect always wins.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    req_valid_d = req_valid_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    redir_pc    = bus.redirect_pc & ~XLEN'(3);
    accept      = req_valid_q && bus.imem_req_ready;

    if (bus.redirect_valid) begin
      pc_d       = redir_pc;
      if_valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (accept) begin
          // Request is on its way; a coincident redirect must kill its response.
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
          if (bus.redirect_valid) begin
            kill_d = 1'b1;
          end else begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(INSTR_BYTES);
          end
        end else begin
          req_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid && (bus.redirect_valid || kill_q)) begin
          // Stale word: drop it and restart from the (possibly new) PC.
          state_d     = ST_REQ;
          kill_d      = 1'b0;
          req_valid_d = 1'b1;
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end else if (bus.imem_rsp_valid) begin
          state_d    = ST_HOLD;
          if_valid_d = 1'b1;
          if_instr_d = bus.imem_rsp_data;
          if_pc_d    = req_pc_q;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid || (if_valid_q && bus.if_ready)) begin
          state_d     = ST_REQ;
          if_valid_d  = 1'b0;
          req_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pCLK) begin
    if (pRST) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counter u_perf (
    .pCLK         (pCLK),
    .pRST         (pRST),
    .fetched_inc  (if_valid_q && bus.if_ready),
    .stall_inc    (if_valid_q && !bus.if_ready),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif
endmodule
